// File: rtl/rf_timing_pkg.sv
// Shared RF timing definitions: FSM state encoding, counter width and default cycle counts.
// Also used by the TX timing block, so keep the encoding stable.
package rf_timing_pkg;

  localparam int CNT_W          = 16;
  localparam int CYC_MAX        = 65535;
  localparam int GUARD_CYC_DEF  = 40;
  localparam int SETTLE_CYC_DEF = 20;
  localparam int WIN_CYC_DEF    = 800;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GUARD  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WINDOW = 3'd3,
    ST_DONE   = 3'd4
  } rf_state_e;

  function automatic logic [CNT_W-1:0] last_cnt(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/rf_phase_cnt.sv
// Loadable up-counter; o_tc flags the cycle the count equals i_last.
// Load has priority over enable.
module rf_phase_cnt
  import rf_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_last);

endmodule

// File: rtl/rf_rx_timing.sv
// RX switch timing: manual pass-through, or timed guard/settle/window sequence after TX end.
// All outputs registered; decode uses the next state so outputs line up with the state register.
module rf_rx_timing
  import rf_timing_pkg::*;
#(
  parameter int GUARD_CYC  = GUARD_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WIN_CYC    = WIN_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx_ctrl,
  input  logic i_init,
  input  logic i_stop,
  input  logic i_tx_over,
  output logic o_rx_ctrl,
  output logic o_rx_valid,
  output logic o_rx_over_flag,
  output logic o_overrun
);

  if (GUARD_CYC < 1 || GUARD_CYC > CYC_MAX) begin : g_bad_guard
    $error("GUARD_CYC must be in 1..65535");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > CYC_MAX) begin : g_bad_settle
    $error("SETTLE_CYC must be in 1..65535");
  end
  if (WIN_CYC < 1 || WIN_CYC > CYC_MAX) begin : g_bad_win
    $error("WIN_CYC must be in 1..65535");
  end

  rf_state_e        r_state;
  rf_state_e        w_state_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_tc;
  logic [CNT_W-1:0] w_last;
  logic             r_rx_ctrl;
  logic             r_rx_valid;
  logic             r_rx_over;
  logic             r_overrun;

  assign w_mode_nxt = i_stop ? 1'b0 : (i_init | r_mode);

  always_comb begin
    w_state_nxt = r_state;
    w_last      = last_cnt(GUARD_CYC);
    case (r_state)
      ST_IDLE:   if (i_tx_over) w_state_nxt = ST_GUARD;
      ST_GUARD:  if (w_tc) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        w_last = last_cnt(SETTLE_CYC);
        if (w_tc) w_state_nxt = ST_WINDOW;
      end
      ST_WINDOW: begin
        w_last = last_cnt(WIN_CYC);
        if (w_tc) w_state_nxt = ST_DONE;
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    // Manual mode or a stop overrides whatever the sequence wanted.
    if (!r_mode || i_stop) w_state_nxt = ST_IDLE;
    w_cnt_load = (w_state_nxt != r_state) || (w_state_nxt == ST_IDLE);
    w_cnt_en   = ~w_cnt_load;
  end

  rf_phase_cnt u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val ('0),
    .i_en       (w_cnt_en),
    .i_last     (w_last),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ctrl  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_over  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_rx_ctrl  <= w_mode_nxt ? ((w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_WINDOW))
                               : i_rx_ctrl;
      r_rx_valid <= (w_state_nxt == ST_WINDOW);
      r_rx_over  <= (w_state_nxt == ST_DONE);
      r_overrun  <= i_tx_over && (r_state != ST_IDLE);
    end
  end

  assign o_rx_ctrl      = r_rx_ctrl;
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_over_flag = r_rx_over;
  assign o_overrun      = r_overrun;

endmodule
